// File: rtl/bridge_host_port_pkg.sv
// Shared types and BRAM layout for the host-side bridge to MM_top.
// The layout functions take the operand section count s.
package bridge_host_port_pkg;

  localparam int unsigned WORD_W   = 17;
  localparam int unsigned PP0_ADDR = 0;
  localparam int unsigned P_BASE   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_DRAIN
  } state_e;

  function automatic int unsigned a_base(input int unsigned s);
    return s + 1;
  endfunction

  function automatic int unsigned b_base(input int unsigned s);
    return 2 * s + 1;
  endfunction

  // Results overwrite the a operand in place.
  function automatic int unsigned res_base(input int unsigned s);
    return s + 1;
  endfunction

  function automatic int unsigned load_words(input int unsigned s);
    return 3 * s + 1;
  endfunction

endpackage

// File: rtl/bridge_host_port_if.sv
// Host-side operand and result streams of the bridge.
// slave is the bridge side, master is the host side.
interface bridge_host_port_if;
  import bridge_host_port_pkg::*;

  logic              s_valid_i;
  logic [WORD_W-1:0] s_data_i;
  logic              s_ready_o;
  logic              m_valid_o;
  logic [WORD_W-1:0] m_data_o;
  logic              m_ready_i;

  modport slave (
    input  s_valid_i, s_data_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o
  );

  modport master (
    output s_valid_i, s_data_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/bridge_rd_fifo.sv
// Small circular readback buffer between BRAM port B and the result stream.
// A push into a full buffer is taken only when a pop frees a slot in the same cycle.
module bridge_rd_fifo
  import bridge_host_port_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bridge_host_port.sv
// Host port of the MM_top bridge: streams operands into BRAM, starts MM_top,
// then streams the result section back out through a small credit-limited buffer.
module bridge_host_port
  import bridge_host_port_pkg::*;
#(
  parameter int unsigned s           = 8,
  parameter int unsigned BRAM_RD_LAT = 1
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  bridge_host_port_if.slave host,
  output logic              mm_start_o,
  input  logic              mm_done_i,
  output logic [31:0]       BRAM_addr_o,
  output logic [WORD_W-1:0] BRAM_din_o,
  input  logic [WORD_W-1:0] BRAM_dout_i,
  output logic              BRAM_we_o,
  output logic              BRAM_en_o,
  output logic              busy_o
);

  localparam int unsigned AW         = $clog2(4 * s);
  localparam int unsigned DEPTH      = BRAM_RD_LAT + 1;
  localparam int unsigned CW         = $clog2(DEPTH + 1);
  localparam int unsigned RES_BASE   = res_base(s);
  localparam int unsigned LOAD_WORDS = load_words(s);

  state_e                 state;
  logic [AW-1:0]          word_cnt;
  logic [AW-1:0]          rd_cnt;
  logic [BRAM_RD_LAT-1:0] rd_vld;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_cnt;
  logic                   fifo_empty;
  logic [WORD_W-1:0]      fifo_rdata;
  logic                   load_hs;
  logic                   rd_issue;
  logic                   pop;
  logic [AW-1:0]          addr_int;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < BRAM_RD_LAT; i++) inflight += CW'(rd_vld[i]);
  end

  // Reads are issued only against free buffer slots, so every returning word has room.
  assign load_hs  = (state == ST_LOAD) && host.s_valid_i;
  assign rd_issue = (state == ST_READ) &&
                    (({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW + 1)'(DEPTH));
  assign pop      = !fifo_empty && host.m_ready_i;

  always_comb begin
    addr_int = '0;
    if (load_hs)       addr_int = word_cnt;
    else if (rd_issue) addr_int = AW'(RES_BASE) + rd_cnt;
  end

  assign host.s_ready_o = (state == ST_LOAD);
  assign host.m_valid_o = !fifo_empty;
  assign host.m_data_o  = fifo_empty ? '0 : fifo_rdata;
  assign BRAM_en_o      = load_hs || rd_issue;
  assign BRAM_we_o      = load_hs;
  assign BRAM_addr_o    = 32'(addr_int);
  assign BRAM_din_o     = load_hs ? host.s_data_i : '0;
  assign mm_start_o     = (state == ST_START);
  assign busy_o         = (state != ST_IDLE);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      rd_cnt   <= '0;
      rd_vld   <= '0;
    end else begin
      rd_vld <= (rd_vld << 1) | BRAM_RD_LAT'(rd_issue);
      case (state)
        ST_IDLE: if (host.s_valid_i) state <= ST_LOAD;
        ST_LOAD: begin
          if (load_hs) begin
            if (word_cnt == AW'(LOAD_WORDS - 1)) begin
              word_cnt <= '0;
              state    <= ST_START;
            end else begin
              word_cnt <= word_cnt + AW'(1);
            end
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT:  if (mm_done_i) state <= ST_READ;
        ST_READ: begin
          if (rd_issue) begin
            if (rd_cnt == AW'(s - 1)) begin
              rd_cnt <= '0;
              state  <= ST_DRAIN;
            end else begin
              rd_cnt <= rd_cnt + AW'(1);
            end
          end
        end
        ST_DRAIN: if (fifo_empty && (inflight == '0)) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  bridge_rd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_rd_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push      (rd_vld[BRAM_RD_LAT-1]),
    .wdata     (BRAM_dout_i),
    .pop       (pop),
    .rdata     (fifo_rdata),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_bridge_host_port.sv
// Directed bench for bridge_host_port (s=8, BRAM read latency 1) with a behavioural BRAM port B.
module tb_bridge_host_port;
  import bridge_host_port_pkg::*;

  localparam int S  = 8;
  localparam int NW = 3 * S + 1;
  localparam int RB = S + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mm_start;
  logic        mm_done = 1'b0;
  logic [31:0] bram_addr;
  logic [16:0] bram_din;
  logic [16:0] bram_dout = '0;
  logic        bram_we;
  logic        bram_en;
  logic        busy;
  logic [16:0] res_val_base = 17'h1AAA0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        valid;
    logic [16:0] data;
    logic        exp_ready;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic [16:0] exp_din;
    logic        exp_busy;
  } vec_t;

  bridge_host_port_if host_if();

  bridge_host_port #(
    .s           (S),
    .BRAM_RD_LAT (1)
  ) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .host        (host_if.slave),
    .mm_start_o  (mm_start),
    .mm_done_i   (mm_done),
    .BRAM_addr_o (bram_addr),
    .BRAM_din_o  (bram_din),
    .BRAM_dout_i (bram_dout),
    .BRAM_we_o   (bram_we),
    .BRAM_en_o   (bram_en),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Port B model: the result region returns res_val_base + index, one cycle after the read.
  always @(posedge clk) begin
    if (bram_en && !bram_we) begin
      if (bram_addr >= RB && bram_addr < RB + S)
        bram_dout <= res_val_base + 17'(bram_addr - RB);
      else
        bram_dout <= 17'h00F0F;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".s_ready"},  host_if.s_ready_o, 0);
    check({tag, ".m_valid"},  host_if.m_valid_o, 0);
    check({tag, ".m_data"},   host_if.m_data_o,  0);
    check({tag, ".mm_start"}, mm_start,  0);
    check({tag, ".addr"},     bram_addr, 0);
    check({tag, ".din"},      bram_din,  0);
    check({tag, ".we"},       bram_we,   0);
    check({tag, ".en"},       bram_en,   0);
    check({tag, ".busy"},     busy,      0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (2) @(negedge clk);
    host_if.s_valid_i = 1'b0;
    host_if.m_ready_i = 1'b0;
    mm_done = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic load_words(input bit gaps, input int reset_at, input int done_at);
    int w = 0;
    int cyc = 0;
    bit started = 0;
    bit hs;
    while (w < NW && cyc < 500) begin
      @(negedge clk);
      cyc++;
      host_if.s_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      host_if.s_data_i  = 17'(w);
      mm_done = (w == done_at);
      #1;
      if (w == reset_at && started) begin
        apply_reset($sformatf("abort%0d", w));
        return;
      end
      hs = host_if.s_valid_i && started;
      check($sformatf("load%0d.ready", w), host_if.s_ready_o, started);
      check($sformatf("load%0d.en", w), bram_en, hs);
      check($sformatf("load%0d.we", w), bram_we, hs);
      check($sformatf("load%0d.addr", w), bram_addr, hs ? w : 0);
      check($sformatf("load%0d.din", w), bram_din, hs ? w : 0);
      check($sformatf("load%0d.mm_start", w), mm_start, 0);
      check($sformatf("load%0d.busy", w), busy, started);
      if (hs) w++;
      if (host_if.s_valid_i && !started) started = 1;
    end
    check("load.words_accepted", w, NW);
    @(negedge clk);
    host_if.s_valid_i = 1'b0;
    mm_done = 1'b0;
    #1;
    check("start.pulse", mm_start, 1);
    check("start.en", bram_en, 0);
    check("start.ready", host_if.s_ready_o, 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("wait.mm_start", mm_start, 0);
      check("wait.en", bram_en, 0);
      check("wait.we", bram_we, 0);
      check("wait.addr", bram_addr, 0);
      check("wait.busy", busy, 1);
      check("wait.m_valid", host_if.m_valid_o, 0);
    end
  endtask

  task automatic read_back(input bit stall, input logic [16:0] base);
    int issued = 0;
    int got = 0;
    int stall_left = 0;
    bit idle = 0;
    res_val_base = base;
    @(negedge clk);
    mm_done = 1'b1;
    host_if.m_ready_i = 1'b1;
    #1;
    check("done.en", bram_en, 0);
    for (int cyc = 0; cyc < 200 && got < S; cyc++) begin
      @(negedge clk);
      mm_done = 1'b0;
      host_if.m_ready_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (bram_en) begin
        check("rd.we", bram_we, 0);
        check($sformatf("rd%0d.addr", issued), bram_addr, RB + issued);
        issued++;
      end
      check("rd.outstanding_le_2", (issued - got) <= 2, 1);
      check("rd.mm_start", mm_start, 0);
      if (host_if.m_valid_o && host_if.m_ready_i) begin
        check($sformatf("res%0d.data", got), host_if.m_data_o, base + 17'(got));
        got++;
        if (got == 1 && stall) stall_left = 10;
      end
    end
    check("rd.words_out", got, S);
    check("rd.reads_issued", issued, S);
    for (int k = 0; k < 4 && !idle; k++) begin
      @(negedge clk);
      #1;
      check("drain.m_valid", host_if.m_valid_o, 0);
      check("drain.en", bram_en, 0);
      if (!busy) idle = 1;
    end
    check("drain.busy_fell", idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b0, 17'h00000, 1'b0, 1'b0, 32'd0, 17'h00000, 1'b0};
    vecs[1] = '{1'b1, 17'h12345, 1'b0, 1'b0, 32'd0, 17'h00000, 1'b0};
    vecs[2] = '{1'b1, 17'h00000, 1'b1, 1'b1, 32'd0, 17'h00000, 1'b1};
    vecs[3] = '{1'b0, 17'h1FFFF, 1'b1, 1'b0, 32'd0, 17'h00000, 1'b1};
    vecs[4] = '{1'b1, 17'h1FFFF, 1'b1, 1'b1, 32'd1, 17'h1FFFF, 1'b1};
    vecs[5] = '{1'b1, 17'h00005, 1'b1, 1'b1, 32'd2, 17'h00005, 1'b1};
    vecs[6] = '{1'b1, 17'h0ABCD, 1'b1, 1'b1, 32'd3, 17'h0ABCD, 1'b1};

    host_if.s_valid_i = 1'b0;
    host_if.s_data_i  = '0;
    host_if.m_ready_i = 1'b0;
    rst_n = 1'b1;
    #1;
    apply_reset("init");

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      host_if.s_valid_i = vecs[i].valid;
      host_if.s_data_i  = vecs[i].data;
      #1;
      check($sformatf("vec%0d.ready", i), host_if.s_ready_o, vecs[i].exp_ready);
      check($sformatf("vec%0d.en", i), bram_en, vecs[i].exp_en);
      check($sformatf("vec%0d.we", i), bram_we, vecs[i].exp_en);
      check($sformatf("vec%0d.addr", i), bram_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d.din", i), bram_din, vecs[i].exp_din);
      check($sformatf("vec%0d.busy", i), busy, vecs[i].exp_busy);
    end
    apply_reset("midload");

    // Continuous load with a stray mm_done during LOAD, then unstalled readback.
    load_words(1'b0, -1, 5);
    read_back(1'b0, 17'h1AAA0);

    // Gapped load, then readback with the host stalling after the first result.
    load_words(1'b1, -1, -1);
    read_back(1'b1, 17'h15550);

    // Abort at word 12, then a clean full operation.
    load_words(1'b0, 12, -1);
    load_words(1'b0, -1, -1);
    read_back(1'b0, 17'h10F00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
